// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control sequencer: Moore FSM driving PC/IR/regfile/memory strobes and datapath muxes.
// Optional MC_PERF_CNT_EN adds cycle_count / instr_retired performance counters.
module mips_multicycle_ctrl #(
  parameter int unsigned FETCH_WAIT_MAX = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        iord,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_control,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal_instr,
  output logic        fetch_timeout
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_retired
`endif
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] stall_q;
  logic        timeout_q;
  logic [3:0]  fdec;
  logic        op_legal;
  logic        pc_write, branch;

  // {legal, alu_control} for R-type funct fields
  function automatic logic [3:0] dec_funct(input logic [5:0] f);
    case (f)
      6'b100000: dec_funct = {1'b1, 3'b010};
      6'b100010: dec_funct = {1'b1, 3'b110};
      6'b100100: dec_funct = {1'b1, 3'b000};
      6'b100101: dec_funct = {1'b1, 3'b001};
      6'b101010: dec_funct = {1'b1, 3'b111};
      default:   dec_funct = 4'b0000;
    endcase
  endfunction

  assign fdec     = dec_funct(funct);
  assign op_legal = (opcode == OP_R) || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = fdec[3] ? S_ALUWB : S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are gated by rst_n so asserting reset kills any strobe in the same cycle.
  always_comb begin
    iord          = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_control   = 3'b000;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_instr = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          alu_src_b   = 2'b01;
          alu_control = ALU_ADD;
          ir_write    = mem_ready;
          pc_write    = mem_ready;
        end
        S_DECODE: begin
          alu_src_b     = 2'b11;
          alu_control   = ALU_ADD;
          illegal_instr = ~op_legal;
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = ALU_ADD;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = mem_ready;
        end
        S_EXEC: begin
          alu_src_a     = 1'b1;
          alu_control   = fdec[2:0];
          illegal_instr = ~fdec[3];
        end
        S_ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = ALU_SUB;
          branch      = 1'b1;
          pc_src      = 2'b01;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
    pc_en = pc_write | (branch & zero);
  end

  assign fetch_timeout = timeout_q;

  // Stall counter saturates at FETCH_WAIT_MAX so the timeout fires only once per fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && !mem_ready) begin
        if (stall_q != FETCH_WAIT_MAX) stall_q <= stall_q + 32'd1;
        timeout_q <= (FETCH_WAIT_MAX != 0) && (stall_q == 32'(FETCH_WAIT_MAX - 1));
      end else begin
        stall_q   <= '0;
        timeout_q <= 1'b0;
      end
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_q, retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (state_d == S_FETCH && state_q != S_FETCH) retired_q <= retired_q + 32'd1;
    end
  end

  assign cycle_count   = cycle_q;
  assign instr_retired = retired_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized scoreboard bench for mips_multicycle_ctrl: per-instruction cycle sequences are
// generated from the instruction class and memory stalls, then compared cycle by cycle.
module tb_mips_multicycle_ctrl;
  localparam int unsigned FWM = 5;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  logic clk = 1'b0;
  logic rst_n, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic iord, mem_write, ir_write, pc_en, alu_src_a, reg_write, reg_dst, mem_to_reg;
  logic illegal_instr, fetch_timeout;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_control;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_count, instr_retired;
`endif

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.FETCH_WAIT_MAX(FWM)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_instr(illegal_instr), .fetch_timeout(fetch_timeout)
`ifdef MC_PERF_CNT_EN
    , .cycle_count(cycle_count), .instr_retired(instr_retired)
`endif
  );

  typedef struct packed {
    logic       iord, mem_write, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_write, reg_dst, mem_to_reg, illegal, timeout;
  } ov_t;

  typedef struct {
    ov_t         v;
    ov_t         m;
    string       nm;
    int unsigned cc;
    int unsigned ir;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  ov_t  e, m;
  logic [5:0] dop, dfn;
  logic dz;
  int   zmode = 2;
  int unsigned ncyc = 0, nret = 0;

  function automatic logic [3:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100000: ref_alu = 4'b1010;
      6'b100010: ref_alu = 4'b1110;
      6'b100100: ref_alu = 4'b1000;
      6'b100101: ref_alu = 4'b1001;
      6'b101010: ref_alu = 4'b1111;
      default:   ref_alu = 4'b0000;
    endcase
  endfunction

  // Fresh cycle: everything expected low, strobes always checked, selects checked only when set.
  task automatic nc();
    e = '0;
    m = '0;
    m.mem_write = 1'b1; m.ir_write = 1'b1; m.pc_en = 1'b1;
    m.reg_write = 1'b1; m.illegal = 1'b1; m.timeout = 1'b1;
    dz = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
  endtask

  task automatic sel(input logic a, input logic [1:0] b, input logic [2:0] c);
    e.alu_src_a = a; e.alu_src_b = b; e.alu_control = c;
    m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_control = '1;
  endtask

  task automatic step(input logic mr, input string nm);
    exp_t x;
    mem_ready = mr; opcode = dop; funct = dfn; zero = dz;
    x.v = e; x.m = m; x.nm = nm; x.cc = ncyc; x.ir = nret;
    q.push_back(x);
    ncyc++;
    @(posedge clk); #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic reset_cycles();
    rst_n = 1'b0;
    ncyc = 0; nret = 0;
    nc(); m = '1; step(1'b0, "RESET");
    ncyc = 0;
    nc(); m = '1; dz = 1'b1; step(1'b1, "RESET");
    ncyc = 0;
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fs, input int ms, input bit abort);
    logic [3:0] fd;
    for (int s = 0; s <= fs; s++) begin
      nc(); sel(1'b0, 2'b01, 3'b010);
      m.iord = 1'b1; m.pc_src = '1;
      dop = 6'($urandom); dfn = 6'($urandom);
      if (s == fs) begin e.ir_write = 1'b1; e.pc_en = 1'b1; end
      e.timeout = (FWM != 0) && (s == int'(FWM));
      step(s == fs, "FETCH");
    end
    dop = op; dfn = fn;
    nc(); sel(1'b0, 2'b11, 3'b010);
    e.illegal = !(op inside {LW, SW, RT, BEQ, ADDI, JMP});
    step(rb(), "DECODE");
    if (e.illegal) begin nret++; return; end
    case (op)
      LW, SW: begin
        nc(); sel(1'b1, 2'b10, 3'b010); step(rb(), "MEMADR");
        for (int s = 0; s <= ms; s++) begin
          nc(); e.iord = 1'b1; m.iord = 1'b1;
          if (op == SW) begin
            if (abort && s == ms) begin reset_cycles(); return; end
            e.mem_write = (s == ms);
            step(s == ms, "MEMWR");
          end else step(s == ms, "MEMRD");
        end
        if (op == LW) begin
          nc(); e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.reg_dst = 1'b0;
          m.mem_to_reg = 1'b1; m.reg_dst = 1'b1;
          step(rb(), "MEMWB");
        end
      end
      RT: begin
        fd = ref_alu(fn);
        nc(); e.alu_src_a = 1'b1; m.alu_src_a = 1'b1; e.alu_src_b = 2'b00; m.alu_src_b = '1;
        if (fd[3]) begin e.alu_control = fd[2:0]; m.alu_control = '1; end
        e.illegal = !fd[3];
        step(rb(), "EXEC");
        if (fd[3]) begin
          nc(); e.reg_dst = 1'b1; e.reg_write = 1'b1; m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
          step(rb(), "ALUWB");
        end
      end
      BEQ: begin
        nc(); sel(1'b1, 2'b00, 3'b110);
        e.pc_src = 2'b01; m.pc_src = '1; e.pc_en = dz;
        step(rb(), "BRANCH");
      end
      ADDI: begin
        nc(); sel(1'b1, 2'b10, 3'b010); step(rb(), "ADDIEX");
        nc(); e.reg_write = 1'b1; m.reg_dst = 1'b1; step(rb(), "ADDIWB");
      end
      default: begin
        nc(); e.pc_src = 2'b10; m.pc_src = '1; e.pc_en = 1'b1;
        step(rb(), "JUMP");
      end
    endcase
    nret++;
  endtask

  exp_t x_mon;
  ov_t  g_mon;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      x_mon = q.pop_front();
      g_mon = {iord, mem_write, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_control,
               reg_write, reg_dst, mem_to_reg, illegal_instr, fetch_timeout};
      n_chk++;
      if (((g_mon ^ x_mon.v) & x_mon.m) != '0) begin
        n_fail++;
        $display("FAIL %s @%0t: got %b expected %b (care %b)", x_mon.nm, $time, g_mon, x_mon.v, x_mon.m);
      end
`ifdef MC_PERF_CNT_EN
      n_chk++;
      if (cycle_count != x_mon.cc || instr_retired != x_mon.ir) begin
        n_fail++;
        $display("FAIL perf %s @%0t: got cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
                 x_mon.nm, $time, cycle_count, instr_retired, x_mon.cc, x_mon.ir);
      end
`endif
    end
  end

  initial begin
    logic [5:0] op, fn;
    logic [5:0] fl [5];
    fl[0] = 6'b100000; fl[1] = 6'b100010; fl[2] = 6'b100100; fl[3] = 6'b100101; fl[4] = 6'b101010;
    rst_n = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
    dop = '0; dfn = '0; dz = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    reset_cycles();
    run_instr(RT, 6'b100000, 0, 0, 1'b0);
    run_instr(LW, 6'b000000, 0, 3, 1'b0);
    zmode = 1; run_instr(BEQ, 6'b000000, 0, 0, 1'b0);
    zmode = 0; run_instr(BEQ, 6'b000000, 1, 0, 1'b0);
    zmode = 2;
    run_instr(6'b111111, 6'b000000, 0, 0, 1'b0);
    run_instr(RT, 6'b111111, 0, 0, 1'b0);
    run_instr(SW, 6'b000000, 0, 2, 1'b0);
    run_instr(ADDI, 6'b000000, 0, 0, 1'b0);
    run_instr(JMP, 6'b000000, 0, 0, 1'b0);
    run_instr(RT, 6'b101010, 12, 0, 1'b0);
    run_instr(RT, 6'b100010, 5, 0, 1'b0);
    run_instr(RT, 6'b100100, 4, 0, 1'b0);
    run_instr(SW, 6'b000000, 1, 2, 1'b1);
    run_instr(JMP, 6'b000000, 0, 0, 1'b0);
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 7))
        0: op = LW;
        1: op = SW;
        2, 6: op = RT;
        3: op = BEQ;
        4: op = ADDI;
        5: op = JMP;
        default: op = 6'($urandom);
      endcase
      fn = ($urandom_range(0, 3) != 0) ? fl[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(op, fn, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8) : $urandom_range(0, 2),
                $urandom_range(0, 3), ($urandom_range(0, 30) == 0) && op == SW);
    end
    @(negedge clk); #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Control sequencer for the multicycle version of the MIPS datapath. It replaces the single-cycle decoder: one shared memory and one ALU are time-multiplexed across fetch, decode, execute, memory and writeback steps, driven by a Moore FSM. It accepts a memory ready handshake so that slow instruction/data memory stalls the sequence. It emits per-cycle mux selects and write strobes to PC, IR, register file and memory.

Parameters:
FETCH_WAIT_MAX, 0, when nonzero, stall cycles in FETCH beyond which fetch_timeout pulses (0 = disabled)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  Instr[31:26] from IR
funct  in  6  Instr[5:0] from IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
iord  out  1  0 = address from PC, 1 = address from ALUOut
mem_write  out  1  data memory write strobe
ir_write  out  1  IR load enable
pc_en  out  1  PC load enable = pc_write | (branch & zero)
pc_src  out  2  00 ALUResult, 01 ALUOut (branch target), 10 jump target
alu_src_a  out  1  0 = PC, 1 = register A
alu_src_b  out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
reg_write  out  1  register file write enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = data register
illegal_instr  out  1  one-cycle pulse on unknown opcode/funct
fetch_timeout  out  1  one-cycle pulse, see FETCH_WAIT_MAX

Behaviour:
- Clock is clk; reset is asynchronous, active-low (rst_n). Reset forces state FETCH; every output 0 immediately, including mid-instruction; no partial write is issued after rst_n falls.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00; ir_write and pc_write asserted only while mem_ready=1; stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next: lw/sw (100011/101011) -> MEMADR; R-type (000000) -> EXEC; beq (000100) -> BRANCH; addi (001000) -> ADDIEX; j (000010) -> JUMP; else pulse illegal_instr, -> FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, add; lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1; waits on mem_ready; -> MEMWB when ready. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; -> FETCH.
- MEMWR: iord=1, mem_write=1 only while mem_ready=1 (exactly one write cycle); -> FETCH when ready.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control by funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); unknown funct -> pulse illegal_instr, -> FETCH, no writeback. Else -> ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, branch=1, pc_src=01; -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add; -> ADDIWB: reg_dst=0, reg_write=1; -> FETCH.
- JUMP: pc_src=10, pc_write=1; -> FETCH.
- Latencies (mem_ready always 1): beq/j 3 cycles, R-type/sw/addi 4, lw 5.
- pc_en is the only output combinational on an input (zero, mem_ready); all others depend on state (plus mem_ready gating).
- fetch_timeout: stall counter in FETCH, clears on leaving FETCH; pulses once when it reaches FETCH_WAIT_MAX, fetch keeps waiting.

Optional Feature:
MC_PERF_CNT_EN: adds outputs cycle_count[31:0] (increments every cycle out of reset) and instr_retired[31:0] (increments on every transition into FETCH from a non-FETCH state, including illegal). Both reset to 0, wrap at 2^32. Without the macro the ports and counters are absent.

Test Plan:
- rst_n low mid-MEMWR (mem_ready=0) -> mem_write, reg_write, pc_en, ir_write all 0 at once; state FETCH after release.
- add (opcode 0, funct 100000), mem_ready=1 -> states FETCH,DECODE,EXEC,ALUWB; alu_control=010, reg_dst=1, reg_write=1 only in cycle 4.
- lw with mem_ready low 3 cycles in MEMRD -> stays MEMRD 4 cycles, MEMWB reg_write=1 mem_to_reg=1 once; total 8 cycles.
- beq with zero=1 -> pc_en=1, pc_src=01 in BRANCH; with zero=0 -> pc_en=0.
- opcode 111111 -> illegal_instr 1-cycle pulse in DECODE, return to FETCH, no write strobes.
- FETCH_WAIT_MAX=5, mem_ready held 0 -> fetch_timeout pulses exactly once after 5 stall cycles; MC_PERF_CNT_EN: instr_retired=0 until first completion.
